alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, operand/result width; legal values are powers of two, 4 to 32.
REQ-002 The block SHALL expose localparam INSTR_W = 2*DATA_W+4, instruction width; fields are funct [INSTR_W-1], a [INSTR_W-2:DATA_W+3], b [DATA_W+2:3], opcode [2:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  instruction present on instruction.
REQ-006 in_ready  output  1  unit can accept an instruction.
REQ-007 instruction  input  INSTR_W  packed instruction, per REQ-002.
REQ-008 out_valid  output  1  result, cb, zero and err are valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 result  output  DATA_W  operation result.
REQ-011 cb  output  1  carry/borrow/shifted-out bit.
REQ-012 zero  output  1  result equals 0.
REQ-013 err  output  1  reserved opcode executed.
REQ-014 busy  output  1  state is not IDLE.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; an instruction is accepted when in_valid and in_ready are both 1.
REQ-017 Opcode table (funct 0/1): 000 ADD/SUB; 001 AND/NAND; 010 OR/NOR; 011 XOR/XNOR; 100 NOT a (funct ignored); 101 logical shift left/right; 110 rotate left/right; 111 reserved.
REQ-018 ADD SHALL set result=(a+b) mod 2^DATA_W with cb=carry out; SUB SHALL set result=(a-b) mod 2^DATA_W with cb=1 iff a<b unsigned.
REQ-019 Logic ops and NOT SHALL set cb=0.
REQ-020 Opcode 111 SHALL set result=0, cb=0, err=1; every other opcode SHALL set err=0.
REQ-021 Non-shift ops accepted in cycle N SHALL register their outputs and enter DONE, with out_valid=1 in cycle N+1.
REQ-022 Shift/rotate ops SHALL load a working register with a and a count k=b[log2(DATA_W)-1:0]; if k=0 the next state is DONE with result=a and cb=0, otherwise SHIFT.
REQ-023 In SHIFT, one bit position SHALL be moved per cycle, k SHALL decrement, and cb SHALL take the bit leaving the MSB (left) or LSB (right); rotate feeds that bit back in, shift inserts 0.
REQ-024 The unit SHALL leave SHIFT for DONE on the cycle k reaches 0; total latency is 1+k cycles, maximum DATA_W.
REQ-025 zero SHALL be computed from the final registered result.
REQ-026 In DONE, result/cb/zero/err SHALL hold stable while out_valid=1 and out_ready=0 (back-pressure of any length).
REQ-027 DONE with out_ready=1 SHALL return to IDLE next cycle; no instruction is accepted in that same cycle (peak throughput is one per 2 cycles).
REQ-028 in_valid while not in IDLE SHALL be ignored; instruction SHALL only be sampled on acceptance.

Reset
REQ-029 While reset_n=0 at a clock edge, state SHALL become IDLE and result=0, cb=0, zero=0, err=0, out_valid=0, busy=0, count=0.
REQ-030 Reset asserted in SHIFT or DONE SHALL abort the operation; the pending result SHALL be discarded and never presented.
REQ-031 in_ready SHALL be 1 in the first cycle after reset_n returns to 1.

Structure
REQ-032 Package alu_pkg SHALL hold the opcode constants, funct meanings and the FSM state typedef.
REQ-033 The combinational single-cycle operations SHALL live in one sub-module alu_datapath (a, b, opcode, funct -> result, cb, err); FSM, shifter and handshake stay in alu_exec_unit.

Verification
REQ-034 DATA_W=8, ADD a=0xF0 b=0x20 -> 1 cycle later out_valid=1, result=0x10, cb=1, zero=0.
REQ-035 SUB a=0x05 b=0x05 -> result=0x00, cb=0, zero=1; SUB a=0x03 b=0x04 -> result=0xFF, cb=1.
REQ-036 Rotate right a=0x81 b=3 -> out_valid 4 cycles after acceptance, result=0x30, cb=0; shift left a=0x81 b=1 -> result=0x02, cb=1; shift with b=0 -> result=a after 1 cycle.
REQ-037 Opcode 111 -> result=0, err=1; next ADD -> err=0.
REQ-038 Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-039 reset_n=0 during the 3rd SHIFT cycle -> next cycle IDLE, out_valid=0, all outputs 0, in_ready=1 after release, no stale result emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings, funct meaning and FSM state type for the ALU execution unit.
package alu_pkg;

  localparam logic [2:0] OP_ADDSUB  = 3'b000;
  localparam logic [2:0] OP_ANDNAND = 3'b001;
  localparam logic [2:0] OP_ORNOR   = 3'b010;
  localparam logic [2:0] OP_XORXNOR = 3'b011;
  localparam logic [2:0] OP_NOT     = 3'b100;
  localparam logic [2:0] OP_SHIFT   = 3'b101;
  localparam logic [2:0] OP_ROTATE  = 3'b110;
  localparam logic [2:0] OP_RSVD    = 3'b111;

  // funct=0 selects ADD/AND/OR/XOR and left moves; funct=1 selects the alternate op and right moves.
  localparam logic FUNCT_ALT = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SHIFT) || (op == OP_ROTATE);
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Single-cycle combinational ALU operations; shift/rotate are sequenced by the parent unit.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        opcode_i,
  input  logic              funct_i,
  output logic [DATA_W-1:0] result_o,
  output logic              cb_o,
  output logic              err_o
);

  logic [DATA_W:0] sum;
  logic            alt;

  assign alt = (funct_i == FUNCT_ALT);

  always_comb begin
    sum      = '0;
    result_o = '0;
    cb_o     = 1'b0;
    err_o    = 1'b0;
    case (opcode_i)
      OP_ADDSUB: begin
        // The extra top bit is the carry for ADD and the borrow (a<b) for SUB.
        if (alt) sum = {1'b0, a_i} - {1'b0, b_i};
        else     sum = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        cb_o     = sum[DATA_W];
      end
      OP_ANDNAND: result_o = alt ? ~(a_i & b_i) : (a_i & b_i);
      OP_ORNOR:   result_o = alt ? ~(a_i | b_i) : (a_i | b_i);
      OP_XORXNOR: result_o = alt ? ~(a_i ^ b_i) : (a_i ^ b_i);
      OP_NOT:     result_o = ~a_i;
      OP_RSVD:    err_o    = 1'b1;
      default:    result_o = a_i;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready front end, bit-serial shifter and DONE hold stage.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W  = 8,
  localparam int INSTR_W = 2 * DATA_W + 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               cb,
  output logic               zero,
  output logic               err,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // in_ready is high only in IDLE, and out_valid holds with stable data until out_ready.

  localparam int CNT_W = $clog2(DATA_W);

  state_t              state_q;
  logic [DATA_W-1:0]   result_q;
  logic                cb_q;
  logic                zero_q;
  logic                err_q;
  logic [CNT_W-1:0]    count_q;
  logic                dir_q;
  logic                rot_q;

  logic                funct_w;
  logic [DATA_W-1:0]   a_w;
  logic [DATA_W-1:0]   b_w;
  logic [2:0]          op_w;
  logic [CNT_W-1:0]    k_w;
  logic [DATA_W-1:0]   dp_result;
  logic                dp_cb;
  logic                dp_err;
  logic [DATA_W-1:0]   shift_d;
  logic                shift_cb_d;

  assign funct_w = instruction[INSTR_W-1];
  assign a_w     = instruction[INSTR_W-2:DATA_W+3];
  assign b_w     = instruction[DATA_W+2:3];
  assign op_w    = instruction[2:0];
  assign k_w     = b_w[CNT_W-1:0];

  alu_datapath #(.DATA_W(DATA_W)) u_datapath (
    .a_i      (a_w),
    .b_i      (b_w),
    .opcode_i (op_w),
    .funct_i  (funct_w),
    .result_o (dp_result),
    .cb_o     (dp_cb),
    .err_o    (dp_err)
  );

  // result_q doubles as the shifter working register while in SHIFT.
  always_comb begin
    if (dir_q == FUNCT_ALT) begin
      shift_cb_d = result_q[0];
      shift_d    = {rot_q & result_q[0], result_q[DATA_W-1:1]};
    end else begin
      shift_cb_d = result_q[DATA_W-1];
      shift_d    = {result_q[DATA_W-2:0], rot_q & result_q[DATA_W-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      cb_q     <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      dir_q    <= 1'b0;
      rot_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (is_shift_op(op_w)) begin
              result_q <= a_w;
              cb_q     <= 1'b0;
              err_q    <= 1'b0;
              count_q  <= k_w;
              dir_q    <= funct_w;
              rot_q    <= (op_w == OP_ROTATE);
              if (k_w == '0) begin
                zero_q  <= (a_w == '0);
                state_q <= DONE;
              end else begin
                zero_q  <= 1'b0;
                state_q <= SHIFT;
              end
            end else begin
              result_q <= dp_result;
              cb_q     <= dp_cb;
              err_q    <= dp_err;
              zero_q   <= (dp_result == '0);
              state_q  <= DONE;
            end
          end
        end
        SHIFT: begin
          result_q <= shift_d;
          cb_q     <= shift_cb_d;
          count_q  <= count_q - CNT_W'(1);
          if (count_q == CNT_W'(1)) begin
            zero_q  <= (shift_d == '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign cb        = cb_q;
  assign zero      = zero_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit at DATA_W=8.
module tb_alu_exec_unit;

  localparam int DATA_W  = 8;
  localparam int INSTR_W = 2 * DATA_W + 4;

  logic               clk;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instruction;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  result;
  logic               cb;
  logic               zero;
  logic               err;
  logic               busy;
  logic [1:0]         dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       f;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       cb;
    int         lat;
  } vec_t;

  alu_exec_unit #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .cb          (cb),
    .zero        (zero),
    .err         (err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers: all called at a negedge and return at a negedge.
  task automatic issue(input logic f, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL issue_wait: in_ready=%b after %0d cycles, required 1", in_ready, n);
    end
    instruction = {f, a, b, op};
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
    instruction = INSTR_W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (result !== 8'h00)   begin errors++; $display("FAIL reset_result: got %h want 00", result); end
    if ({cb, zero, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {cb, zero, err}); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    issue(1'b0, 8'hF0, 8'h20, 3'b000);
    checks += 5;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: out_valid=%b want 1", out_valid); end
    if (result !== 8'h10)   begin errors++; $display("FAIL add_result: got %h want 10", result); end
    if (cb !== 1'b1)        begin errors++; $display("FAIL add_cb: got %b want 1", cb); end
    if (zero !== 1'b0)      begin errors++; $display("FAIL add_zero: got %b want 0", zero); end
    if (err !== 1'b0)       begin errors++; $display("FAIL add_err: got %b want 0", err); end
    consume();
    checks += 2;
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL add_idle: in_ready=%b want 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL add_idle_valid: out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_sub();
    issue(1'b1, 8'h05, 8'h05, 3'b000);
    checks += 4;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_eq_valid: got %b want 1", out_valid); end
    if (result !== 8'h00)   begin errors++; $display("FAIL sub_eq_result: got %h want 00", result); end
    if (cb !== 1'b0)        begin errors++; $display("FAIL sub_eq_cb: got %b want 0", cb); end
    if (zero !== 1'b1)      begin errors++; $display("FAIL sub_eq_zero: got %b want 1", zero); end
    consume();
    issue(1'b1, 8'h03, 8'h04, 3'b000);
    checks += 3;
    if (result !== 8'hFF)   begin errors++; $display("FAIL sub_borrow_result: got %h want ff", result); end
    if (cb !== 1'b1)        begin errors++; $display("FAIL sub_borrow_cb: got %b want 1", cb); end
    if (zero !== 1'b0)      begin errors++; $display("FAIL sub_borrow_zero: got %b want 0", zero); end
    consume();
  endtask

  task automatic test_logic_ops();
    vec_t v[$];
    int   lat;
    v.push_back('{1'b0, 8'hF0, 8'h3C, 3'b001, 8'h30, 1'b0, 1});
    v.push_back('{1'b1, 8'hF0, 8'h3C, 3'b001, 8'hCF, 1'b0, 1});
    v.push_back('{1'b0, 8'hF0, 8'h0F, 3'b010, 8'hFF, 1'b0, 1});
    v.push_back('{1'b1, 8'hF0, 8'h0F, 3'b010, 8'h00, 1'b0, 1});
    v.push_back('{1'b0, 8'hAA, 8'hFF, 3'b011, 8'h55, 1'b0, 1});
    v.push_back('{1'b1, 8'hAA, 8'h0F, 3'b011, 8'h5A, 1'b0, 1});
    v.push_back('{1'b1, 8'h0F, 8'hFF, 3'b100, 8'hF0, 1'b0, 1});
    v.push_back('{1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1});
    v.push_back('{1'b1, 8'h00, 8'h01, 3'b000, 8'hFF, 1'b1, 1});
    foreach (v[i]) begin
      issue(v[i].f, v[i].a, v[i].b, v[i].op);
      wait_done(lat);
      checks += 5;
      if (lat != v[i].lat)      begin errors++; $display("FAIL logic_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      if (result !== v[i].res)  begin errors++; $display("FAIL logic_result[%0d]: got %h want %h", i, result, v[i].res); end
      if (cb !== v[i].cb)       begin errors++; $display("FAIL logic_cb[%0d]: got %b want %b", i, cb, v[i].cb); end
      if (zero !== (v[i].res == 8'h00)) begin errors++; $display("FAIL logic_zero[%0d]: got %b want %b", i, zero, v[i].res == 8'h00); end
      if (err !== 1'b0)         begin errors++; $display("FAIL logic_err[%0d]: got %b want 0", i, err); end
      consume();
    end
  endtask

  task automatic test_shift();
    vec_t v[$];
    int   lat;
    v.push_back('{1'b1, 8'h81, 8'h03, 3'b110, 8'h30, 1'b0, 4});
    v.push_back('{1'b0, 8'h81, 8'h01, 3'b101, 8'h02, 1'b1, 2});
    v.push_back('{1'b0, 8'h5A, 8'h08, 3'b101, 8'h5A, 1'b0, 1});
    v.push_back('{1'b1, 8'h81, 8'h01, 3'b101, 8'h40, 1'b1, 2});
    v.push_back('{1'b0, 8'h81, 8'h07, 3'b110, 8'hC0, 1'b0, 8});
    v.push_back('{1'b1, 8'hF8, 8'hFC, 3'b101, 8'h0F, 1'b1, 5});
    v.push_back('{1'b0, 8'h80, 8'h01, 3'b101, 8'h00, 1'b1, 2});
    v.push_back('{1'b0, 8'h01, 8'h0F, 3'b101, 8'h80, 1'b0, 8});
    foreach (v[i]) begin
      issue(v[i].f, v[i].a, v[i].b, v[i].op);
      wait_done(lat);
      checks += 5;
      if (lat != v[i].lat)      begin errors++; $display("FAIL shift_lat[%0d]: got %0d want %0d", i, lat, v[i].lat); end
      if (result !== v[i].res)  begin errors++; $display("FAIL shift_result[%0d]: got %h want %h", i, result, v[i].res); end
      if (cb !== v[i].cb)       begin errors++; $display("FAIL shift_cb[%0d]: got %b want %b", i, cb, v[i].cb); end
      if (zero !== (v[i].res == 8'h00)) begin errors++; $display("FAIL shift_zero[%0d]: got %b want %b", i, zero, v[i].res == 8'h00); end
      if (err !== 1'b0)         begin errors++; $display("FAIL shift_err[%0d]: got %b want 0", i, err); end
      consume();
    end
  endtask

  task automatic test_reserved();
    issue(1'b0, 8'hFF, 8'hFF, 3'b111);
    checks += 4;
    if (result !== 8'h00) begin errors++; $display("FAIL rsvd_result: got %h want 00", result); end
    if (cb !== 1'b0)      begin errors++; $display("FAIL rsvd_cb: got %b want 0", cb); end
    if (err !== 1'b1)     begin errors++; $display("FAIL rsvd_err: got %b want 1", err); end
    if (zero !== 1'b1)    begin errors++; $display("FAIL rsvd_zero: got %b want 1", zero); end
    consume();
    issue(1'b0, 8'h01, 8'h02, 3'b000);
    checks += 2;
    if (result !== 8'h03) begin errors++; $display("FAIL rsvd_next_result: got %h want 03", result); end
    if (err !== 1'b0)     begin errors++; $display("FAIL rsvd_next_err: got %b want 0", err); end
    consume();
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    issue(1'b0, 8'h12, 8'h34, 3'b000);
    for (int c = 0; c < 10; c++) begin
      if (c % 3 == 1) begin
        in_valid    = 1'b1;
        instruction = {1'b1, 8'hAA, 8'h55, 3'b011};
      end else begin
        in_valid    = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h46 ||
          {cb, zero, err} !== 3'b000) begin
        errors++;
        bad++;
        $display("FAIL hold[%0d]: valid=%b ready=%b result=%h flags=%b want 1 0 46 000",
                 c, out_valid, in_ready, result, {cb, zero, err});
      end
    end
    // Keep a request pending through the release cycle; it must not be taken there.
    in_valid    = 1'b1;
    instruction = {1'b1, 8'h09, 8'h02, 3'b000};
    consume();
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1)  begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL release_busy: got %b want 0", busy); end
    @(negedge clk);
    in_valid = 1'b0;
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pending_valid: got %b want 1", out_valid); end
    if (result !== 8'h07)   begin errors++; $display("FAIL pending_result: got %h want 07", result); end
    consume();
  endtask

  task automatic test_reset_in_shift();
    int stale = 0;
    issue(1'b0, 8'h81, 8'h05, 3'b110);
    repeat (2) @(negedge clk);
    checks += 2;
    if (busy !== 1'b1)      begin errors++; $display("FAIL pre_reset_busy: got %b want 1", busy); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pre_reset_valid: got %b want 0", out_valid); end
    reset_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d want 0", dbg_state); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    if (result !== 8'h00)   begin errors++; $display("FAIL abort_result: got %h want 00", result); end
    if ({cb, zero, err, busy} !== 4'b0000) begin errors++; $display("FAIL abort_flags: got %b want 0000", {cb, zero, err, busy}); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 8; c++) begin
      if (out_valid === 1'b1) stale++;
      @(negedge clk);
    end
    checks++;
    if (stale != 0) begin errors++; $display("FAIL abort_stale: out_valid seen %0d cycles want 0", stale); end
    issue(1'b0, 8'h20, 8'h22, 3'b000);
    checks++;
    if (result !== 8'h42) begin errors++; $display("FAIL abort_recover: got %h want 42", result); end
    consume();
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    instruction = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_logic_ops();
    test_shift();
    test_reserved();
    test_back_to_back();
    test_reset_in_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
